// File: rtl/blit_scheduler.sv
// Blit command scheduler: buffers CPU blit commands in a small FIFO and issues
// them one at a time to the blitter, accumulating collision results.
module blit_scheduler #(
    parameter int DEPTH       = 4,
    parameter bit VBLANK_GATE = 1'b0,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [2:0]             cmd_op,
    input  logic [11:0]            cmd_src,
    input  logic [3:0]             cmd_height,
    input  logic [6:0]             cmd_destX,
    input  logic [5:0]             cmd_destY,
    input  logic                   vblank,
    output logic [2:0]             blit_op,
    output logic [11:0]            blit_src,
    output logic [3:0]             blit_srcHeight,
    output logic [6:0]             blit_destX,
    output logic [5:0]             blit_destY,
    output logic                   blit_enable,
    input  logic                   blit_ready,
    input  logic                   blit_collision,
    output logic                   idle,
    output logic                   collision,
    input  logic                   collision_clr,
    output logic                   done_pulse,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    // IDLE: wait/pop | ISSUE: enable pulse | WAIT_ACK: ready fall or timeout | WAIT_DONE: ready rise
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic [31:0]   blit_q, blit_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          collision_q, collision_d;
    logic          vb_meta_q, vb_meta_d;
    logic          vb_s_q, vb_s_d;
    logic          push, pop;

    assign cmd_ready   = (level_q != LW'(DEPTH));
    assign push        = cmd_valid && cmd_ready;
    assign idle        = (level_q == '0) && (state_q == IDLE);
    assign blit_enable = (state_q == ISSUE);
    assign collision   = collision_q;
    assign level       = level_q;
    assign {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY} = blit_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {cmd_op, cmd_src, cmd_height, cmd_destX, cmd_destY};
        end
    end

    always_comb begin
        state_d     = state_q;
        blit_d      = blit_q;
        cnt_d       = cnt_q;
        collision_d = collision_q;
        pop         = 1'b0;
        done_pulse  = 1'b0;
        vb_meta_d   = vblank;
        vb_s_d      = vb_meta_q;
        case (state_q)
            IDLE: begin
                if ((level_q != '0) && blit_ready && (!VBLANK_GATE || vb_s_q)) begin
                    pop     = 1'b1;
                    blit_d  = mem_q[rd_ptr_q];
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'(ACK_TIMEOUT);
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (!blit_ready) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q <= 8'd1) begin
                    // blitter never acknowledged: retire without collision
                    done_pulse = 1'b1;
                    state_d    = IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            WAIT_DONE: begin
                if (blit_ready) begin
                    done_pulse  = 1'b1;
                    collision_d = collision_q | blit_collision;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (collision_clr) begin
            collision_d = 1'b0;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            blit_q      <= '0;
            cnt_q       <= '0;
            collision_q <= 1'b0;
            vb_meta_q   <= 1'b0;
            vb_s_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            blit_q      <= blit_d;
            cnt_q       <= cnt_d;
            collision_q <= collision_d;
            vb_meta_q   <= vb_meta_d;
            vb_s_q      <= vb_s_d;
        end
    end
endmodule

// File: tb/tb_blit_scheduler.sv
// Self-checking bench for blit_scheduler: a behavioural blitter plus an
// in-order command/collision reference model.
module tb_blit_scheduler;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int ACK   = 15;

    logic clk = 1'b0;
    logic rst_n;
    logic cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [11:0] cmd_src;
    logic [3:0] cmd_height;
    logic [6:0] cmd_destX;
    logic [5:0] cmd_destY;
    logic vblank;
    logic [2:0] blit_op;
    logic [11:0] blit_src;
    logic [3:0] blit_srcHeight;
    logic [6:0] blit_destX;
    logic [5:0] blit_destY;
    logic blit_enable, blit_ready, blit_collision;
    logic idle, collision, done_pulse;
    logic [LW-1:0] level;
    logic task_clr, bm_clr, collision_clr;
    logic [31:0] blit_word;

    logic cmd_valid2, cmd_ready2, blit_enable2, blit_ready2, idle2, collision2, done_pulse2;
    logic blit_collision2, collision_clr2;
    logic [2:0] op2;
    logic [11:0] src2;
    logic [3:0] h2;
    logic [6:0] x2;
    logic [5:0] y2;
    logic [LW-1:0] level2;
    logic [31:0] blit2_word;

    assign collision_clr   = task_clr | bm_clr;
    assign blit_word       = {blit_op, blit_src, blit_srcHeight, blit_destX, blit_destY};
    assign blit2_word      = {op2, src2, h2, x2, y2};
    assign blit_collision2 = 1'b0;
    assign collision_clr2  = 1'b0;

    blit_scheduler #(.DEPTH(DEPTH), .VBLANK_GATE(1'b0), .ACK_TIMEOUT(ACK)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_height(cmd_height),
        .cmd_destX(cmd_destX), .cmd_destY(cmd_destY), .vblank(vblank),
        .blit_op(blit_op), .blit_src(blit_src), .blit_srcHeight(blit_srcHeight),
        .blit_destX(blit_destX), .blit_destY(blit_destY), .blit_enable(blit_enable),
        .blit_ready(blit_ready), .blit_collision(blit_collision), .idle(idle),
        .collision(collision), .collision_clr(collision_clr), .done_pulse(done_pulse),
        .level(level)
    );

    blit_scheduler #(.DEPTH(DEPTH), .VBLANK_GATE(1'b1), .ACK_TIMEOUT(ACK)) dut_vb (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_height(cmd_height),
        .cmd_destX(cmd_destX), .cmd_destY(cmd_destY), .vblank(vblank),
        .blit_op(op2), .blit_src(src2), .blit_srcHeight(h2),
        .blit_destX(x2), .blit_destY(y2), .blit_enable(blit_enable2),
        .blit_ready(blit_ready2), .blit_collision(blit_collision2), .idle(idle2),
        .collision(collision2), .collision_clr(collision_clr2), .done_pulse(done_pulse2),
        .level(level2)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] obs_q[$];
    logic [31:0] exp_q[$];
    int en_cyc_q[$];
    int done_cyc_q[$];
    int en_total = 0, en_wide = 0, done_total = 0;
    int en2_total = 0, en2_cyc = 0, done2_total = 0;
    bit en_prev = 1'b0;

    // blitter model controls
    bit bm_hold = 1'b0, bm_nodrop = 1'b0, bm_len_rand = 1'b0, bm_clr_at_done = 1'b0;
    bit bm_pend = 1'b0, bm_cur = 1'b0;
    int bm_len = 10, bm_busy = 0;
    bit bm_coll_q[$];

    initial forever #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Blitter: drops ready the cycle after enable, stays busy, then raises ready with its collision result.
    initial begin
        blit_ready = 1'b1;
        blit_collision = 1'b0;
        bm_clr = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bm_clr = 1'b0;
            if (bm_hold) begin
                blit_ready = 1'b0;
            end else if (bm_busy > 0) begin
                bm_busy--;
                if (bm_busy == 0) begin
                    blit_ready = 1'b1;
                    blit_collision = bm_cur;
                    if (bm_clr_at_done) begin
                        bm_clr = 1'b1;
                        bm_clr_at_done = 1'b0;
                    end
                end
            end else if (bm_pend) begin
                bm_pend = 1'b0;
                blit_ready = 1'b0;
                blit_collision = 1'b0;
                bm_cur = (bm_coll_q.size() != 0) ? bm_coll_q.pop_front() : 1'b0;
                bm_busy = bm_len_rand ? int'($urandom_range(1, 8)) : bm_len;
            end else if (bm_nodrop) begin
                blit_ready = 1'b1;
                blit_collision = 1'b1;
            end else if (!blit_ready) begin
                blit_ready = 1'b1;
            end
            if (blit_enable && !bm_nodrop && !bm_hold) bm_pend = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (blit_enable) begin
                obs_q.push_back(blit_word);
                en_cyc_q.push_back(cyc);
                en_total++;
                if (en_prev) en_wide++;
            end
            en_prev = blit_enable;
            if (done_pulse) begin
                done_total++;
                done_cyc_q.push_back(cyc);
            end
            if (blit_enable2) begin
                en2_total++;
                en2_cyc = cyc;
            end
            if (done_pulse2) done2_total++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        obs_q.delete();
        exp_q.delete();
        en_cyc_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic push_cmd(input logic [31:0] w, output bit ok, output int pcyc);
        cmd_valid = 1'b1;
        {cmd_op, cmd_src, cmd_height, cmd_destX, cmd_destY} = w;
        @(negedge clk);
        ok = cmd_ready;
        pcyc = cyc;
        step(1);
        cmd_valid = 1'b0;
        if (ok) exp_q.push_back(w);
    endtask

    task automatic wait_done(input int target, input int bound, output bit ok);
        int n;
        n = 0;
        while (done_total < target && n < bound) begin
            step(1);
            n++;
        end
        ok = (done_total >= target);
    endtask

    task automatic test_reset();
        checks++;
        if (level !== LW'(0) || cmd_ready !== 1'b1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo: level=%0d ready=%b idle=%b, expected 0 1 1", level, cmd_ready, idle);
        end
        checks++;
        if (blit_enable !== 1'b0 || done_pulse !== 1'b0 || collision !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: en=%b done=%b coll=%b, expected 0 0 0", blit_enable, done_pulse, collision);
        end
        checks++;
        if (blit_word !== 32'h0) begin
            errors++;
            $display("FAIL reset_blit: got %h expected 00000000", blit_word);
        end
    endtask

    task automatic test_single();
        logic [31:0] w;
        bit ok;
        int pc, d0, e0;
        w = {3'd1, 12'h050, 4'd5, 7'd1, 6'd1};
        clear_model();
        d0 = done_total;
        e0 = en_total;
        push_cmd(w, ok, pc);
        wait_done(d0 + 1, 100, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done: no done_pulse within 100 cycles");
        end
        step(20);
        checks++;
        if (en_total - e0 != 1 || en_wide != 0) begin
            errors++;
            $display("FAIL single_enable: pulses=%0d wide=%0d, expected 1 0", en_total - e0, en_wide);
        end
        checks++;
        if (en_cyc_q.size() != 1 || en_cyc_q[0] - pc != 2) begin
            errors++;
            $display("FAIL single_latency: got %0d expected 2", (en_cyc_q.size() != 0) ? en_cyc_q[0] - pc : -1);
        end
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== w || blit_word !== w) begin
            errors++;
            $display("FAIL single_fields: got %h expected %h", blit_word, w);
        end
        checks++;
        if (done_total - d0 != 1 || idle !== 1'b1) begin
            errors++;
            $display("FAIL single_idle: done=%0d idle=%b, expected 1 1", done_total - d0, idle);
        end
    endtask

    task automatic test_back_to_back();
        bit okv [5];
        bit ok;
        int pc, d0, e0;
        bm_hold = 1'b1;
        step(3);
        clear_model();
        d0 = done_total;
        e0 = en_total;
        for (int i = 0; i < 5; i++) push_cmd($urandom(), okv[i], pc);
        checks++;
        if ({okv[0], okv[1], okv[2], okv[3], okv[4]} !== 5'b11110) begin
            errors++;
            $display("FAIL full_accept: got %b expected 11110", {okv[0], okv[1], okv[2], okv[3], okv[4]});
        end
        checks++;
        if (level !== LW'(4) || cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_level: level=%0d ready=%b, expected 4 0", level, cmd_ready);
        end
        step(20);
        checks++;
        if (en_total != e0) begin
            errors++;
            $display("FAIL stall_busy: got %0d enables expected 0", en_total - e0);
        end
        bm_hold = 1'b0;
        wait_done(d0 + 4, 400, ok);
        checks++;
        if (!ok || level !== LW'(0) || idle !== 1'b1) begin
            errors++;
            $display("FAIL drain: done=%0d level=%0d idle=%b, expected 4 0 1", done_total - d0, level, idle);
        end
        checks++;
        if (obs_q.size() != 4) begin
            errors++;
            $display("FAIL drain_count: got %0d expected 4", obs_q.size());
        end
        for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL order_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_collision();
        bit bits [3];
        bit ok, exp_coll;
        int pc, d0;
        bits[0] = 1'b0; bits[1] = 1'b1; bits[2] = 1'b0;
        task_clr = 1'b1;
        step(1);
        task_clr = 1'b0;
        checks++;
        if (collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_clear: got %b expected 0", collision);
        end
        clear_model();
        bm_coll_q.delete();
        for (int i = 0; i < 3; i++) bm_coll_q.push_back(bits[i]);
        d0 = done_total;
        exp_coll = 1'b0;
        for (int i = 0; i < 3; i++) push_cmd($urandom(), ok, pc);
        for (int k = 0; k < 3; k++) begin
            wait_done(d0 + k + 1, 100, ok);
            exp_coll = exp_coll | bits[k];
            checks++;
            if (!ok || collision !== exp_coll) begin
                errors++;
                $display("FAIL coll_sticky_%0d: got %b expected %b (done seen %b)", k, collision, exp_coll, ok);
            end
        end
        bm_coll_q.push_back(1'b1);
        bm_clr_at_done = 1'b1;
        push_cmd($urandom(), ok, pc);
        wait_done(d0 + 4, 100, ok);
        checks++;
        if (!ok || collision !== 1'b0) begin
            errors++;
            $display("FAIL coll_clr_wins: got %b expected 0", collision);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int pc, d0;
        logic c0;
        bm_nodrop = 1'b1;
        step(3);
        clear_model();
        c0 = collision;
        d0 = done_total;
        push_cmd($urandom(), ok, pc);
        push_cmd($urandom(), ok, pc);
        wait_done(d0 + 2, 200, ok);
        checks++;
        if (!ok || done_cyc_q.size() != 2 || en_cyc_q.size() != 2 || done_cyc_q[0] - en_cyc_q[0] != ACK) begin
            errors++;
            $display("FAIL timeout_len: got %0d expected %0d", (done_cyc_q.size() != 0 && en_cyc_q.size() != 0) ? done_cyc_q[0] - en_cyc_q[0] : -1, ACK);
        end
        checks++;
        if (en_cyc_q.size() != 2 || en_cyc_q[1] - en_cyc_q[0] != ACK + 2) begin
            errors++;
            $display("FAIL timeout_next: got %0d expected %0d", (en_cyc_q.size() == 2) ? en_cyc_q[1] - en_cyc_q[0] : -1, ACK + 2);
        end
        checks++;
        if (collision !== c0 || obs_q.size() != 2 || obs_q[0] !== exp_q[0] || obs_q[1] !== exp_q[1]) begin
            errors++;
            $display("FAIL timeout_state: coll=%b cmds=%0d, expected %b 2 in order", collision, obs_q.size(), c0);
        end
        bm_nodrop = 1'b0;
        step(3);
    endtask

    task automatic test_vblank();
        logic [31:0] w;
        int x;
        w = $urandom();
        cmd_valid2 = 1'b1;
        {cmd_op, cmd_src, cmd_height, cmd_destX, cmd_destY} = w;
        @(negedge clk);
        checks++;
        if (cmd_ready2 !== 1'b1) begin
            errors++;
            $display("FAIL vb_push: ready=%b expected 1", cmd_ready2);
        end
        step(1);
        cmd_valid2 = 1'b0;
        step(1000);
        checks++;
        if (en2_total != 0 || level2 !== LW'(1) || idle2 !== 1'b0) begin
            errors++;
            $display("FAIL vb_gate: enables=%0d level=%0d idle=%b, expected 0 1 0", en2_total, level2, idle2);
        end
        vblank = 1'b1;
        x = cyc;
        step(4);
        checks++;
        if (en2_total != 1 || en2_cyc - x != 3) begin
            errors++;
            $display("FAIL vb_latency: enables=%0d delay=%0d, expected 1 3", en2_total, en2_cyc - x);
        end
        checks++;
        if (blit2_word !== w) begin
            errors++;
            $display("FAIL vb_fields: got %h expected %h", blit2_word, w);
        end
        blit_ready2 = 1'b0;
        vblank = 1'b0;
        step(6);
        checks++;
        if (done2_total != 0 || level2 !== LW'(0)) begin
            errors++;
            $display("FAIL vb_midblit: done=%0d level=%0d, expected 0 0", done2_total, level2);
        end
        blit_ready2 = 1'b1;
        step(2);
        checks++;
        if (done2_total != 1 || idle2 !== 1'b1 || blit2_word !== w || collision2 !== 1'b0) begin
            errors++;
            $display("FAIL vb_complete: done=%0d idle=%b coll=%b, expected 1 1 0", done2_total, idle2, collision2);
        end
    endtask

    task automatic test_random();
        localparam int N = 12;
        logic [31:0] w;
        bit ok, c, exp_coll;
        int pc, d0, tries;
        task_clr = 1'b1;
        step(1);
        task_clr = 1'b0;
        clear_model();
        bm_coll_q.delete();
        bm_len_rand = 1'b1;
        exp_coll = 1'b0;
        d0 = done_total;
        for (int i = 0; i < N; i++) begin
            w = $urandom();
            c = 1'($urandom_range(0, 1));
            ok = 1'b0;
            tries = 0;
            while (!ok && tries < 200) begin
                push_cmd(w, ok, pc);
                tries++;
            end
            if (ok) begin
                bm_coll_q.push_back(c);
                exp_coll = exp_coll | c;
            end
            step($urandom_range(0, 6));
        end
        wait_done(d0 + N, 2000, ok);
        checks++;
        if (!ok || obs_q.size() != N || exp_q.size() != N) begin
            errors++;
            $display("FAIL rand_count: issued=%0d accepted=%0d done=%0d expected %0d", obs_q.size(), exp_q.size(), done_total - d0, N);
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL rand_cmd_%0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        checks++;
        if (collision !== exp_coll || level !== LW'(0) || idle !== 1'b1) begin
            errors++;
            $display("FAIL rand_final: coll=%b level=%0d idle=%b, expected %b 0 1", collision, level, idle, exp_coll);
        end
        bm_len_rand = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int pc, d0, e0, n;
        clear_model();
        bm_coll_q.delete();
        bm_coll_q.push_back(1'b1);
        d0 = done_total;
        push_cmd($urandom(), ok, pc);
        wait_done(d0 + 1, 100, ok);
        checks++;
        if (!ok || collision !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre_coll: got %b expected 1", collision);
        end
        bm_len = 30;
        e0 = en_total;
        for (int i = 0; i < 3; i++) push_cmd($urandom(), ok, pc);
        n = 0;
        while (en_total == e0 && n < 50) begin
            step(1);
            n++;
        end
        step(3);
        checks++;
        if (en_total != e0 + 1 || level !== LW'(2)) begin
            errors++;
            $display("FAIL rst_pre_level: enables=%0d level=%0d, expected 1 2", en_total - e0, level);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (level !== LW'(0) || cmd_ready !== 1'b1 || idle !== 1'b1 || blit_enable !== 1'b0 || done_pulse !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_fifo: level=%0d ready=%b idle=%b en=%b done=%b", level, cmd_ready, idle, blit_enable, done_pulse);
        end
        checks++;
        if (collision !== 1'b0 || blit_word !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_regs: coll=%b blit=%h, expected 0 00000000", collision, blit_word);
        end
        step(2);
        rst_n = 1'b1;
        e0 = en_total;
        step(60);
        checks++;
        if (en_total != e0 || idle !== 1'b1 || level !== LW'(0)) begin
            errors++;
            $display("FAIL rst_no_issue: enables=%0d idle=%b level=%0d, expected 0 1 0", en_total - e0, idle, level);
        end
        bm_len = 10;
    endtask

    initial begin
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_valid2 = 1'b0;
        blit_ready2 = 1'b1;
        cmd_op = '0;
        cmd_src = '0;
        cmd_height = '0;
        cmd_destX = '0;
        cmd_destY = '0;
        vblank = 1'b0;
        task_clr = 1'b0;
        #2;
        test_reset();
        step(2);
        rst_n = 1'b1;
        step(2);
        test_single();
        test_back_to_back();
        test_collision();
        test_timeout();
        test_vblank();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/blit_scheduler.md
Name: blit_scheduler

Overview:
- Command queue and sequencer between the CPU and the blitter.
- The CPU pushes blit commands with a valid/ready handshake. The block buffers them in a small FIFO, then issues them one at a time on the blitter's enable/ready handshake.
- Collision results are accumulated per command and reported back. Issue can optionally be restricted to vertical blank to avoid tearing.

Parameters:
- DEPTH, 4, FIFO entries; must be a power of two, 2..16.
- VBLANK_GATE, 0, 1 = start a command only while synchronized vblank is high.
- ACK_TIMEOUT, 15, cycles to wait for blit_ready to fall after enable; 1..255.

Ports:
- clk  in  1  system clock (the blitter clock)
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  CPU command strobe
- cmd_ready  out  1  FIFO not full
- cmd_op  in  3  blit operation code
- cmd_src  in  12  source address in CPU RAM
- cmd_height  in  4  sprite height
- cmd_destX  in  7  destination X
- cmd_destY  in  6  destination Y
- vblank  in  1  vertical-blank flag, asynchronous (VGA clock domain)
- blit_op  out  3  registered operation to blitter
- blit_src  out  12  registered source
- blit_srcHeight  out  4  registered height
- blit_destX  out  7  registered destination X
- blit_destY  out  6  registered destination Y
- blit_enable  out  1  one-cycle start pulse
- blit_ready  in  1  blitter idle
- blit_collision  in  1  blitter collision flag, valid when blit_ready rises
- idle  out  1  FIFO empty and FSM in IDLE
- collision  out  1  sticky OR of collision over all commands completed since last clear
- collision_clr  in  1  clears collision; clear wins over a simultaneous set
- done_pulse  out  1  one cycle per completed command
- level  out  clog2(DEPTH)+1  FIFO occupancy

Behaviour:
- Reset (async, rst_n low) values:
  - FIFO empty, level = 0, cmd_ready = 1, idle = 1.
  - blit_enable = 0, done_pulse = 0, collision = 0.
  - All blit_* command outputs = 0.
  - FSM in IDLE; vblank synchronizer = 0.
- Reset mid-operation abandons the in-flight command and flushes the FIFO. The blitter is not signalled.
- FIFO:
  - Push when cmd_valid && cmd_ready. The 32-bit entry is packed as {op, src, height, destX, destY}.
  - cmd_ready = (level != DEPTH), combinational from registered level.
  - Push and pop in the same cycle leave level unchanged. This is legal when full: cmd_ready stays 0 that cycle, so no push occurs when full.
  - Pointers wrap modulo DEPTH.
- vblank passes through a 2-flop synchronizer to vb_s. Latency 2 cycles.
- FSM states:
  - IDLE: if FIFO non-empty, blit_ready = 1, and (VBLANK_GATE == 0 or vb_s = 1), pop the head. Latch it into the blit_* registers and go to ISSUE.
  - ISSUE: blit_enable = 1 for exactly this one cycle. Load the timeout counter with ACK_TIMEOUT. Go to WAIT_ACK.
  - WAIT_ACK: if blit_ready = 0, go to WAIT_DONE. Otherwise decrement the counter. At 0, treat the command as completed with no collision: done_pulse = 1, go to IDLE.
  - WAIT_DONE: on blit_ready = 1, OR blit_collision into collision, done_pulse = 1, go to IDLE.
- blit_* outputs hold their values from the pop until the next pop. The blitter may sample them at any time while busy.
- Minimum issue interval is 4 cycles: IDLE, ISSUE, WAIT_ACK, WAIT_DONE.
- A command may be popped in the same cycle done_pulse is asserted only on the following IDLE cycle. No back-to-back pop in the completion cycle.
- The VBLANK_GATE check applies only at start. A command running when vblank ends completes normally.
- idle = (level == 0) && state == IDLE. It is registered-state derived, with no combinational path from cmd_valid.
- blit_ready low in IDLE (blitter busy from another master) stalls issue indefinitely.

Test Plan:
- Reset, then push 1 command (op=1, src=0x050, h=5, X=1, Y=1) with blit_ready = 1; the blitter model drops ready 1 cycle after enable and raises it 10 cycles later:
  - enable pulses exactly 1 cycle, 2 cycles after push.
  - blit_* equal the pushed values.
  - done_pulse once; idle returns to 1.
- Push 5 commands back-to-back with DEPTH=4 while blit_ready is held 0:
  - cmd_ready drops after the 4th push; level = 4.
  - Releasing ready issues the commands in push order; level reaches 0.
- Collision accumulation:
  - 2nd of 3 commands returns collision = 1; the sticky flag sets at its completion and stays 1.
  - Asserting collision_clr in the same cycle as a 4th colliding completion leaves collision = 0.
- Blitter model that never drops ready:
  - WAIT_ACK expires after 15 cycles; done_pulse = 1; collision unchanged.
  - The next queued command issues afterwards.
- VBLANK_GATE=1:
  - With vblank = 0, a queued command does not issue for 1000 cycles.
  - vblank rising produces enable 3 cycles later (2 sync cycles + 1 pop cycle).
  - Dropping vblank mid-blit does not abort the command.
- Assert rst_n low during WAIT_DONE with 2 entries queued:
  - All outputs return to reset values immediately.
  - No enable pulse follows the reset release.
